bcd_to_bin: RTL and testbench
=============================

BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of BCD input digits.
REQ-002 SHALL have parameter BIN_W, default 32, binary output width.
REQ-003 SHALL have port clk_100kHz, input, 1, sole clock, all logic on its rising edge.
REQ-004 SHALL have port rst_, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, request conversion of the current digit inputs.
REQ-006 SHALL have ports bcd0..bcd7, input, 4 each, BCD digits; bcd0 is the least significant and bcd7 the most significant.
REQ-007 SHALL have port bin, output, BIN_W, registered binary result.
REQ-008 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1, single-cycle pulse when bin is updated.
REQ-010 SHALL have port err, output, 1, high when the last conversion had an input digit greater than 9.

Function
REQ-011 SHALL implement an FSM with states IDLE and CONV.
REQ-012 In IDLE, start=1 at edge k SHALL capture bcd7..bcd0 into a 32-bit digit register.
- The same edge k SHALL clear a 32-bit shift register and a 6-bit iteration counter, set busy, and enter CONV.
REQ-013 At edge k, err_pending SHALL be set if any captured digit exceeds 9.
REQ-014 Each CONV edge SHALL perform one reverse double-dabble iteration:
- shift {digit register, shift register} right by one bit;
- then subtract 3 from every digit-register nibble whose value is 8 or more.
REQ-015 Conversion SHALL take exactly 32 iterations, on edges k+1 through k+32.
REQ-016 At edge k+32 the FSM SHALL update outputs and return to IDLE:
- bin <= shift register result, or 0 if err_pending;
- err <= err_pending;
- done <= 1 for exactly one cycle;
- busy <= 0.
REQ-017 bin and err SHALL hold their values until the next completion or reset.
REQ-018 start SHALL be ignored while busy=1; the conversion in progress SHALL be unaffected.
REQ-019 start=1 in the cycle after done SHALL be accepted, giving back-to-back conversions of 33 cycles each.
REQ-020 Digit inputs SHALL only be sampled at the start edge; later changes SHALL have no effect on the result.
REQ-021 The maximum legal input 99999999 SHALL convert without overflow (27 significant bits); bin[31:27] SHALL be 0 for legal inputs.
REQ-022 done and busy SHALL never be high in the same cycle.

Reset
REQ-023 rst_=0 SHALL immediately force:
- state to IDLE;
- bin, busy, done and err to 0;
- the internal digit register, shift register, counter and err_pending to 0.
REQ-024 Reset during CONV SHALL abort the conversion with no done pulse; the first start after rst_ rises SHALL convert normally.

Structure
REQ-025 A shared package SHALL hold N_DIGITS, BIN_W, the iteration count of 32, the FSM state encoding, and the digit limit 9.
REQ-026 Per-nibble correction (subtract 3 if the nibble is 8 or more) SHALL be a sub-module bcd_nibble_adjust, instantiated once per digit.
REQ-027 No other sub-modules SHALL be used.

Verification
REQ-028 Digits 1,2,3,4,5,6,7,8 (bcd7..bcd0) with start -> bin=32'h00BC614E, done at edge k+32, err=0.
REQ-029 Digits all 9 -> bin=32'h05F5E0FF, err=0; digits all 0 -> bin=0, err=0.
REQ-030 bcd3=4'hA with other digits 0 -> after 32 iterations done=1, err=1, bin=0.
REQ-031 start pulsed at k+5 and k+20 during a conversion of 00000042 -> a single done, bin=42.
- Then start in the cycle after done with digits 00000007 -> second done 33 cycles later, bin=7.
REQ-032 rst_ pulsed low at k+10 of a conversion -> no done, all outputs 0.
- A following conversion of 00001000 -> bin=1000.
REQ-033 Digit inputs changed at k+1 after starting 00000123 -> bin=123.

Source files
------------

// File: rtl/bcd_to_bin_pkg.sv
// Shared constants, state encoding and digit helpers for the BCD-to-binary converter.
package bcd_to_bin_pkg;

  localparam int N_DIGITS = 8;
  localparam int BIN_W    = 32;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = 6;

  localparam logic [3:0] DIGIT_MAX  = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB    = 4'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_e;

  function automatic logic digit_illegal(input logic [3:0] d);
    return d > DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Reverse double-dabble correction for one BCD digit: after a right shift a
// digit that picked up a carried-in half-ten reads 8 or more and must drop by 3.
module bcd_nibble_adjust
  import bcd_to_bin_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  // Subtract 3 from nibbles of 8 or more, pass the rest through.
  always_comb begin
    nib_o = nib_i;
    if (nib_i >= ADJ_THRESH) nib_o = nib_i - ADJ_SUB;
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Serial BCD-to-binary converter using reverse double-dabble, one bit per clock.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; bin/err hold the last completed result
// ST_CONV | one shift/correct iteration per edge, 32 edges in total
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int N_DIGITS = bcd_to_bin_pkg::N_DIGITS,
  parameter int BIN_W    = bcd_to_bin_pkg::BIN_W
) (
  input  logic             clk_100kHz,
  input  logic             rst_,
  input  logic             start,
  input  logic [3:0]       bcd0,
  input  logic [3:0]       bcd1,
  input  logic [3:0]       bcd2,
  input  logic [3:0]       bcd3,
  input  logic [3:0]       bcd4,
  input  logic [3:0]       bcd5,
  input  logic [3:0]       bcd6,
  input  logic [3:0]       bcd7,
  output logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int DIG_W = 4 * N_DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_CNT - 1);

  state_e             state_q, state_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [BIN_W-1:0]   shr_q, shr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               errp_q, errp_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [31:0]            bcd_all;
  logic [DIG_W-1:0]       dig_in;
  logic                   any_bad;
  logic [DIG_W+BIN_W-1:0] cat_sh;
  logic [DIG_W-1:0]       dig_sh;
  logic [DIG_W-1:0]       dig_adj;
  logic [BIN_W-1:0]       shr_next;

  assign bcd_all = {bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};
  assign dig_in  = DIG_W'(bcd_all);

  // Flag any captured digit outside 0..9.
  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_illegal(dig_in[4*i +: 4])) any_bad = 1'b1;
    end
  end

  assign cat_sh   = {dig_q, shr_q} >> 1;
  assign dig_sh   = cat_sh[DIG_W+BIN_W-1:BIN_W];
  assign shr_next = cat_sh[BIN_W-1:0];

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .nib_i(dig_sh[4*g +: 4]),
      .nib_o(dig_adj[4*g +: 4])
    );
  end

  // Next-state and datapath decode; done defaults low so it pulses one cycle.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    shr_d   = shr_q;
    cnt_d   = cnt_q;
    errp_d  = errp_q;
    bin_d   = bin_q;
    err_d   = err_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dig_d   = dig_in;
          shr_d   = '0;
          cnt_d   = '0;
          errp_d  = any_bad;
          busy_d  = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        dig_d = dig_adj;
        shr_d = shr_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          bin_d   = errp_q ? '0 : shr_next;
          err_d   = errp_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_100kHz or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      dig_q   <= '0;
      shr_q   <= '0;
      cnt_q   <= '0;
      errp_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      shr_q   <= shr_d;
      cnt_q   <= cnt_d;
      errp_q  <= errp_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bin  = bin_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
`timescale 1ns/1ps
module tb_bcd_to_bin;

  logic        clk_100kHz = 1'b0;
  logic        rst_ = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  bcd0 = '0, bcd1 = '0, bcd2 = '0, bcd3 = '0;
  logic [3:0]  bcd4 = '0, bcd5 = '0, bcd6 = '0, bcd7 = '0;
  logic [31:0] bin;
  logic        busy, done, err;

  bcd_to_bin dut (
    .clk_100kHz(clk_100kHz), .rst_(rst_), .start(start),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
    .bcd4(bcd4), .bcd5(bcd5), .bcd6(bcd6), .bcd7(bcd7),
    .bin(bin), .busy(busy), .done(done), .err(err)
  );

  always #5 clk_100kHz = ~clk_100kHz;

  typedef struct {
    logic [31:0] bin;
    logic        err;
    int          k;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  always @(posedge clk_100kHz) cyc++;

  // Reference: decimal value of the packed digits by plain arithmetic.
  function automatic exp_t model(input logic [31:0] d);
    exp_t e;
    int   v;
    logic bad;
    logic [31:0] t;
    v = 0; bad = 1'b0; t = d;
    for (int i = 7; i >= 0; i--) begin
      int nib;
      nib = int'((t >> (4 * i)) & 32'hF);
      if (nib > 9) bad = 1'b1;
      v = v * 10 + nib;
    end
    e.bin = bad ? 32'd0 : 32'(v);
    e.err = bad;
    e.k   = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic set_digits(input logic [31:0] d);
    {bcd7, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0} = d;
  endtask

  // Called at a falling edge with the DUT idle: start is sampled on the next rising edge.
  task automatic issue(input logic [31:0] d, input logic [31:0] eb, input logic ee, input bit push);
    exp_t e;
    set_digits(d);
    start = 1'b1;
    if (push) begin
      e.bin = eb; e.err = ee; e.k = cyc + 1;
      sbq.push_back(e);
    end
    @(negedge clk_100kHz);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy || sbq.size() != 0) begin
      @(negedge clk_100kHz);
      #2;
      n++;
      if (n > 200) begin
        n_assert++; n_fail++;
        $display("FAIL wait_idle: timeout, busy=%0b pending=%0d", busy, sbq.size());
        sbq.delete();
        break;
      end
    end
    @(negedge clk_100kHz);
  endtask

  task automatic conv(input logic [31:0] d, input logic [31:0] eb, input logic ee);
    wait_idle();
    issue(d, eb, ee, 1'b1);
    wait_idle();
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin
    forever begin
      @(negedge clk_100kHz);
      if (done) begin
        check("busy_with_done", {31'd0, busy}, 32'd0);
        if (sbq.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d, required none", cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("bin", bin, e.bin);
          check("err", {31'd0, err}, {31'd0, e.err});
          check("latency", 32'(cyc - e.k), 32'd32);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kk;
    int n;
    logic [31:0] d;
    exp_t e;

    repeat (3) @(negedge clk_100kHz);
    check("rst_bin", bin, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_ = 1'b1;
    repeat (2) @(negedge clk_100kHz);

    conv(32'h12345678, 32'h00BC614E, 1'b0);
    conv(32'h99999999, 32'h05F5E0FF, 1'b0);
    conv(32'h00000000, 32'h00000000, 1'b0);
    conv(32'h0000A000, 32'h00000000, 1'b1);

    // start ignored while busy, then back-to-back conversion
    wait_idle();
    kk = cyc + 1;
    issue(32'h00000042, 32'd42, 1'b0, 1'b1);
    while (cyc < kk + 4) @(negedge clk_100kHz);
    issue(32'h99999999, 32'd0, 1'b0, 1'b0);
    while (cyc < kk + 19) @(negedge clk_100kHz);
    issue(32'h00000555, 32'd0, 1'b0, 1'b0);
    n = 0;
    do begin
      @(negedge clk_100kHz);
      n++;
    end while (!done && n < 60);
    if (!done) begin
      n_assert++; n_fail++;
      $display("FAIL b2b_done: got no done, required done");
    end
    issue(32'h00000007, 32'd7, 1'b0, 1'b1);
    wait_idle();

    // reset in the middle of a conversion
    kk = cyc + 1;
    issue(32'h11111111, 32'd0, 1'b0, 1'b0);
    while (cyc < kk + 10) @(negedge clk_100kHz);
    rst_ = 1'b0;
    #1;
    check("abort_bin", bin, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_err", {31'd0, err}, 32'd0);
    @(negedge clk_100kHz);
    rst_ = 1'b1;
    repeat (40) @(negedge clk_100kHz);
    check("abort_no_done_bin", bin, 32'd0);
    conv(32'h00001000, 32'd1000, 1'b0);

    // digits changed right after the start edge
    wait_idle();
    issue(32'h00000123, 32'd123, 1'b0, 1'b1);
    set_digits(32'h99999999);
    wait_idle();

    // randomized conversions with random idle gaps
    for (int t = 0; t < 40; t++) begin
      d = 32'd0;
      for (int i = 0; i < 8; i++) d = d | (32'($urandom_range(9, 0)) << (4 * i));
      if ($urandom_range(7, 0) == 0)
        d = d | (32'($urandom_range(15, 10)) << (4 * $urandom_range(7, 0)));
      e = model(d);
      wait_idle();
      repeat ($urandom_range(2, 0)) @(negedge clk_100kHz);
      issue(d, e.bin, e.err, 1'b1);
      if ($urandom_range(1, 0) == 1) set_digits($urandom);
    end
    wait_idle();

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
